// File: rtl/alu_seq_ctrl_pkg.sv
// Shared types and constants for the ALU command sequencer and its ALU.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_CAT = 2'b11;

  localparam logic [7:0] ACC_RST = 8'h00;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Command/status bundle between a requester (master) and the sequencer (slave).
interface alu_seq_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [3:0] cmd_count;
  logic       cmd_clr;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       ovf;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_count, cmd_clr,
    input  cmd_ready, busy, done, result, ovf
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_count, cmd_clr,
    output cmd_ready, busy, done, result, ovf
  );
endinterface

// File: rtl/alu_seq_ctrl_alu.sv
// Combinational 4-bit ALU: add with carry, OR-flag, AND-flag, concat {A,B}.
// Zero latency, no handshake.
module alu
  import alu_seq_pkg::*;
(
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [1:0] Function,
  output logic [7:0] ALUout
);

  logic [4:0] w_sum;

  assign w_sum = {1'b0, A} + {1'b0, B};

  always_comb begin
    ALUout = ACC_RST;
    case (Function)
      OP_ADD: ALUout = {3'b000, w_sum};
      OP_OR:  ALUout = {7'd0, |(A | B)};
      OP_AND: ALUout = {7'd0, &(A & B)};
      OP_CAT: ALUout = {A, B};
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Runs one accepted command N+1 times through the ALU into an 8-bit accumulator; N+3 cycles per command,
// cmd_ready only in IDLE (no queue). Sticky add-carry flag built only with ALU_SEQ_OVF_EN.
module alu_seq_ctrl
  import alu_seq_pkg::*;
(
  input  logic           Clock,
  input  logic           Reset_b,
  alu_seq_ctrl_if.slave  bus
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_op;
  logic [3:0] r_data;
  logic [3:0] r_remaining;
  logic [7:0] r_acc;
  logic [7:0] w_alu_out;
  logic       w_accept;
  logic       w_ready;
  logic       w_busy;
  logic       w_done;

  // Operand B is only the accumulator low nibble, so add carry (bit 4) never feeds back.
  alu u_alu (
    .A        (r_data),
    .B        (r_acc[3:0]),
    .Function (r_op),
    .ALUout   (w_alu_out)
  );

  always_ff @(posedge Clock) begin
    if (Reset_b) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_ready     = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (bus.cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        w_busy = 1'b1;
        if (r_remaining == 4'd0) w_state_nxt = DONE;
      end
      DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset_b) begin
      r_acc       <= ACC_RST;
      r_remaining <= 4'd0;
      r_op        <= OP_ADD;
      r_data      <= 4'd0;
    end else if (w_accept) begin
      r_op        <= bus.cmd_op;
      r_data      <= bus.cmd_data;
      r_remaining <= bus.cmd_count;
      if (bus.cmd_clr) r_acc <= ACC_RST;
    end else if (r_state == EXEC) begin
      r_acc <= w_alu_out;
      if (r_remaining != 4'd0) r_remaining <= r_remaining - 4'd1;
    end
  end

`ifdef ALU_SEQ_OVF_EN
  logic r_ovf;

  always_ff @(posedge Clock) begin
    if (Reset_b)                      r_ovf <= 1'b0;
    else if (w_accept && bus.cmd_clr) r_ovf <= 1'b0;
    else if (r_state == EXEC && r_op == OP_ADD && w_alu_out[4]) r_ovf <= 1'b1;
  end

  assign bus.ovf = r_ovf;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.cmd_ready = w_ready;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.result    = r_acc;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl; expected values hand-computed.
module tb_alu_seq_ctrl;

  logic Clock;
  logic Reset_b;
  int   checks;
  int   errors;
  int   lat;
  int   done_cnt;
  logic exp_ovf;

  alu_seq_ctrl_if bus ();

  alu_seq_ctrl dut (
    .Clock   (Clock),
    .Reset_b (Reset_b),
    .bus     (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [3:0] data,
                       input logic [3:0] cnt, input logic clr);
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    bus.cmd_count = cnt;
    bus.cmd_clr   = clr;
  endtask

  // Accept a command at edge t, then return in the DONE cycle; lat = cycles from t to done.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] data,
                         input logic [3:0] cnt, input logic clr, output int latency);
    drive(op, data, cnt, clr);
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    latency = 1;
    while (bus.done !== 1'b1 && latency < 40) begin
      tick();
      latency++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
`ifdef ALU_SEQ_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif

    // Reset held with a valid command present: reset must win.
    Reset_b       = 1'b1;
    bus.cmd_valid = 1'b1;
    drive(2'b00, 4'h1, 4'h0, 1'b1);
    tick();
    tick();
    check("rst_ready",  {7'd0, bus.cmd_ready}, 8'h01);
    check("rst_busy",   {7'd0, bus.busy},      8'h00);
    check("rst_done",   {7'd0, bus.done},      8'h00);
    check("rst_result", bus.result,            8'h00);
    check("rst_ovf",    {7'd0, bus.ovf},       8'h00);
    Reset_b       = 1'b0;
    bus.cmd_valid = 1'b0;
    tick();
    check("idle_after_rst_busy", {7'd0, bus.busy}, 8'h00);

    // add 3 x5 from 0 -> 0x0F, done in t+6
    run_cmd(2'b00, 4'h3, 4'd4, 1'b1, lat);
    check("t1_latency", 8'(lat),            8'd6);
    check("t1_result",  bus.result,         8'h0F);
    check("t1_busy",    {7'd0, bus.busy},   8'h01);
    check("t1_ready",   {7'd0, bus.cmd_ready}, 8'h00);
    check("t1_ovf",     {7'd0, bus.ovf},    8'h00);
    tick();
    check("t1_ready_back", {7'd0, bus.cmd_ready}, 8'h01);
    check("t1_done_low",   {7'd0, bus.done},      8'h00);
    check("t1_result_hold", bus.result,           8'h0F);

    // add 5 x4 from 0 -> 5,A,F,0x14 (carry on last)
    run_cmd(2'b00, 4'h5, 4'd3, 1'b1, lat);
    check("t2_latency", 8'(lat),          8'd5);
    check("t2_result",  bus.result,       8'h14);
    check("t2_ovf",     {7'd0, bus.ovf},  {7'd0, exp_ovf});
    tick();

    // concat A with acc low nibble 4 -> 0xA4, 3-cycle occupancy
    run_cmd(2'b11, 4'hA, 4'd0, 1'b0, lat);
    check("t3_latency", 8'(lat),          8'd2);
    check("t3_result",  bus.result,       8'hA4);
    check("t3_ovf_sticky", {7'd0, bus.ovf}, {7'd0, exp_ovf});
    tick();
    check("t3_ready_back", {7'd0, bus.cmd_ready}, 8'h01);

    // preload acc = 0x0F, clearing ovf
    run_cmd(2'b00, 4'hF, 4'd0, 1'b1, lat);
    check("pre_result", bus.result,      8'h0F);
    check("pre_ovf",    {7'd0, bus.ovf}, 8'h00);
    tick();

    // AND-flag with F: F&F -> 1, then F&1 -> 0
    drive(2'b10, 4'hF, 4'd1, 1'b0);
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    check("t4_exec1_acc", bus.result, 8'h0F);
    tick();
    check("t4_exec2_acc", bus.result,        8'h01);
    check("t4_no_done",   {7'd0, bus.done},  8'h00);
    tick();
    check("t4_done",   {7'd0, bus.done}, 8'h01);
    check("t4_result", bus.result,       8'h00);
    tick();

    // cmd_valid held through EXEC with changed fields: ignored until IDLE
    drive(2'b00, 4'h1, 4'd2, 1'b1);
    bus.cmd_valid = 1'b1;
    tick();
    drive(2'b01, 4'h0, 4'd0, 1'b0);
    check("t5_ready_exec", {7'd0, bus.cmd_ready}, 8'h00);
    check("t5_acc0",       bus.result,            8'h00);
    tick();
    check("t5_acc1", bus.result, 8'h01);
    tick();
    check("t5_acc2", bus.result, 8'h02);
    tick();
    check("t5_done",   {7'd0, bus.done},      8'h01);
    check("t5_result", bus.result,            8'h03);
    check("t5_ready_done", {7'd0, bus.cmd_ready}, 8'h00);
    tick();
    check("t5_idle_ready", {7'd0, bus.cmd_ready}, 8'h01);
    check("t5_idle_busy",  {7'd0, bus.busy},      8'h00);
    tick();
    bus.cmd_valid = 1'b0;
    check("t5_second_busy", {7'd0, bus.busy}, 8'h01);
    tick();
    check("t5_second_done",   {7'd0, bus.done}, 8'h01);
    check("t5_second_result", bus.result,       8'h01);
    tick();

    // Reset during 2nd EXEC cycle of a count=7 command
    drive(2'b00, 4'h1, 4'd7, 1'b1);
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    check("t6_exec2_acc", bus.result, 8'h01);
    Reset_b = 1'b1;
    tick();
    Reset_b = 1'b0;
    check("t6_ready",  {7'd0, bus.cmd_ready}, 8'h01);
    check("t6_busy",   {7'd0, bus.busy},      8'h00);
    check("t6_result", bus.result,            8'h00);
    check("t6_done",   {7'd0, bus.done},      8'h00);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done === 1'b1) done_cnt++;
    end
    check("t6_no_done_pulse", 8'(done_cnt), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
